ps2_kbd_receiver: RTL and testbench
===================================

# ps2_kbd_receiver

PS/2 keyboard receiver that deserializes the keyboard's ps2_clk/ps2_data line into 8-bit scan codes and buffers them in a small FIFO. It sits directly upstream of the scan-code-to-ASCII lookup. The consumer reads `data` while `ready` is high and pops entries with `nextdata_n`. The block checks frame integrity (start, odd parity, stop) and recovers from truncated frames with an idle timeout.

## Interface
- `FIFO_AW`, default 3: FIFO address width. Depth is 2^FIFO_AW slots. Usable capacity is 2^FIFO_AW − 1 bytes (7 at default).
- `TIMEOUT_CYCLES`, default 50000: number of clk cycles without a ps2_clk falling edge, mid-frame, before the frame is abandoned.
- `clk`  in  1  system clock, all logic on its rising edge.
- `clrn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ps2_clk`  in  1  raw PS/2 clock from the keyboard, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the keyboard, asynchronous.
- `nextdata_n`  in  1  active-low pop request, sampled on every rising clk edge.
- `data`  out  8  oldest FIFO byte while `ready` is high. Reads 8'h00 when the FIFO is empty.
- `ready`  out  1  high when the FIFO is non-empty.
- `overflow`  out  1  sticky flag: a received byte was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded (bad parity, bad stop bit, or timeout).

## Operation
- **Synchronizers.**
  - `ps2_clk` passes through a 3-flop shift register `s[2:0]`. A falling edge is detected when s[2]=1 and s[1]=0, giving a one-cycle `fall` strobe.
  - `ps2_data` passes through a 2-flop synchronizer and is sampled in the `fall` cycle.
- **Frame counter.** `cnt` runs 0..10 and advances only on `fall`.
  - cnt=0 (start bit): sampled 0 → cnt=1. Sampled 1 → stay at 0, no error (line noise/idle).
  - cnt=1..8: data bits, LSB first, shifted into `shreg[7:0]`.
  - cnt=9: parity bit latched.
  - cnt=10: stop bit. If stop=1 and XOR(shreg, parity)=1 (odd parity), push `shreg`. Otherwise pulse `frame_err` and push nothing. cnt returns to 0 in either case.
- **Timeout.**
  - `idle` counter clears on every `fall` and whenever cnt=0. It increments otherwise.
  - When it reaches TIMEOUT_CYCLES−1: cnt←0, idle←0, `frame_err` pulses, partial byte discarded.
- **FIFO.**
  - Storage: `mem[2^FIFO_AW]`, pointers `wp`/`rp` of FIFO_AW bits that wrap naturally.
  - empty = (wp==rp); full = (wp+1==rp).
  - `ready` = !empty. `data` = ready ? mem[rp] : 8'h00 (combinational from registered state).
  - Push when not full: mem[wp]←byte, wp++.
  - Push when full: byte dropped, `overflow`←1.
  - Pop: on each rising edge with nextdata_n=0 and ready=1, rp++. A pop while empty is ignored.
  - The consumer must issue one-cycle low pulses; a held-low `nextdata_n` pops one entry per cycle.
  - `overflow` is cleared by a successful pop, except when a drop occurs in that same cycle (set wins).
- **Simultaneous push and pop.**
  - Full/empty are evaluated on pre-edge pointers.
  - Not full: both happen and occupancy is unchanged.
  - Full: the pop happens, the pushed byte is dropped, and `overflow`=1.
  - Empty: the push happens and the pop is ignored.

## Timing
- Reset (clrn=0, immediate): cnt=0, idle=0, wp=rp=0, shreg=0, synchronizers=all 1s, ready=0, data=8'h00, overflow=0, frame_err=0. FIFO contents are not cleared.
- Reset asserted mid-frame abandons the frame. The first frame after release is received normally if its start bit arrives after release.
- Pin falling edge → `fall`: 2–3 clk cycles.
- Stop-bit `fall` in cycle N → `ready`=1 and `data` valid from cycle N+1. A `frame_err` for a bad frame is also high in cycle N+1, for one cycle.
- Pop at edge E → `data` shows the next entry (or 8'h00 if empty) from E onward. `ready` drops at E if that was the last entry.
- Requirement: the PS/2 clock period (60–100 µs) must be ≥ 8 clk cycles. At 50 MHz, a TIMEOUT_CYCLES of 50000 gives 1 ms.

## Test plan
- **Single valid frame.** Byte 8'h1C, parity 0, stop 1, at 10 kHz with a 50 MHz clk → ready=1 and data=8'h1C one cycle after the stop bit's `fall`. A nextdata_n pulse → ready=0, data=8'h00.
- **Sequence order.** Frames F0, 1C, F0 back-to-back with no pops → ready=1. Three pops read F0, 1C, F0 in order, then ready=0. frame_err never pulses.
- **Parity error.** 8'h1C sent with parity 1 → frame_err pulses once, ready stays 0. The next valid 8'h32 frame is received correctly.
- **Overflow.** 8 valid frames 01..08 with no pops → 01..07 stored and 08 dropped, overflow=1. A pop returns 01 and clears overflow. The remaining pops return 02..07.
- **Timeout recovery.** Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES → frame_err pulses, cnt=0. A following full frame 8'h5A is received intact.
- **Reset mid-frame.** clrn pulsed low after 6 bits of a frame → all outputs 0 immediately. The next complete frame 8'h29 is received with ready=1.

Source files
------------

// File: rtl/ps2_kbd_if.sv
// ps2_kbd_if: scan-code FIFO read port between the PS/2 receiver and its consumer
interface ps2_kbd_if;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;
   modport master (input nextdata_n, output data, ready, overflow, frame_err);
   modport slave (output nextdata_n, input data, ready, overflow, frame_err);
endinterface

// File: rtl/ps2_kbd_receiver.sv
// ps2_kbd_receiver: deserializes PS/2 frames, checks start/odd parity/stop, buffers bytes in a FIFO
module ps2_kbd_receiver #(
   parameter int FIFO_AW        = 3,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   ps2_kbd_if.master   bus
);
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   logic [2:0]         s;
   logic [1:0]         d;
   logic [3:0]         cnt, cnt_n;
   logic [7:0]         shreg, shreg_n;
   logic               par, par_n;
   logic [IW-1:0]      idle, idle_n;
   logic               err_q;
   logic [FIFO_AW-1:0] wp, rp;
   logic [7:0]         mem [2**FIFO_AW];
   logic               fall, timeout, push, err, empty, full, pop, wr, drop;
   assign fall    = s[2] & ~s[1];
   assign timeout = (cnt != 4'd0) && (idle == IW'(TIMEOUT_CYCLES - 1));
   assign empty   = wp == rp;
   assign full    = wp + FIFO_AW'(1) == rp;
   assign pop     = ~bus.nextdata_n & ~empty;
   assign wr      = push & ~full;
   assign drop    = push & full;
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         s            <= 3'b111;
         d            <= 2'b11;
         cnt          <= 4'd0;
         shreg        <= 8'h00;
         par          <= 1'b0;
         idle         <= '0;
         err_q        <= 1'b0;
         wp           <= '0;
         rp           <= '0;
         bus.overflow <= 1'b0;
      end else begin
         s            <= {s[1:0], ps2_clk};
         d            <= {d[0], ps2_data};
         cnt          <= cnt_n;
         shreg        <= shreg_n;
         par          <= par_n;
         idle         <= idle_n;
         err_q        <= err;
         wp           <= wr ? wp + FIFO_AW'(1) : wp;
         rp           <= pop ? rp + FIFO_AW'(1) : rp;
         bus.overflow <= drop ? 1'b1 : pop ? 1'b0 : bus.overflow;
      end
   end
   // storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= shreg;
   end
   always_comb begin
      cnt_n   = cnt;
      shreg_n = shreg;
      par_n   = par;
      push    = 1'b0;
      err     = 1'b0;
      if (fall) begin
         if (cnt == 4'd0) cnt_n = d[1] ? 4'd0 : 4'd1;
         else if (cnt <= 4'd8) begin
            shreg_n = {d[1], shreg[7:1]};
            cnt_n   = cnt + 4'd1;
         end else if (cnt == 4'd9) begin
            par_n = d[1];
            cnt_n = 4'd10;
         end else begin
            cnt_n = 4'd0;
            push  = d[1] & (^{shreg, par});
            err   = ~push;
         end
      end else if (timeout) begin
         cnt_n = 4'd0;
         err   = 1'b1;
      end
      idle_n = (fall || timeout || cnt == 4'd0) ? '0 : idle + IW'(1);
   end
   assign bus.ready     = ~empty;
   assign bus.data      = empty ? 8'h00 : mem[rp];
   assign bus.frame_err = err_q;
endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// tb_ps2_kbd_receiver: directed PS/2 frames with a scoreboard checked on every pop
module tb_ps2_kbd_receiver;
   localparam int TO = 200;
   localparam int H  = 10;
   logic clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   int checks = 0, failures = 0, err_seen = 0, err_exp = 0;
   logic [7:0] exp_q[$];
   logic [7:0] e;
   logic prev_err = 1'b0;
   ps2_kbd_if bus();
   ps2_kbd_receiver #(.FIFO_AW(3), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus.master));
   always #10 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.frame_err) begin
         err_seen++;
         if (prev_err) begin
            checks++;
            failures++;
            $display("FAIL frame_err_width actual=2+ cycles expected=1");
         end
      end
      prev_err = bus.frame_err;
      if (!bus.nextdata_n && bus.ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pop actual=%0h expected=none", bus.data);
         end else begin
            e = exp_q.pop_front();
            chk("pop_data", {24'h0, bus.data}, {24'h0, e});
         end
      end
   end
   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (H) @(posedge clk);
      #3 ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      #3 ps2_clk = 1'b1;
   endtask
   task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0, input int nbits = 11);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
      ps2_data = 1'b1;
      repeat (3 * H) @(posedge clk);
   endtask
   task automatic pop();
      @(posedge clk);
      #1 bus.nextdata_n = 1'b0;
      @(posedge clk);
      #1 bus.nextdata_n = 1'b1;
      @(negedge clk);
   endtask
   initial begin
      bus.nextdata_n = 1'b1;
      #5;
      chk("reset_ready", {31'h0, bus.ready}, 0);
      chk("reset_data", {24'h0, bus.data}, 0);
      chk("reset_overflow", {31'h0, bus.overflow}, 0);
      chk("reset_frame_err", {31'h0, bus.frame_err}, 0);
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      send(8'h1C);
      exp_q.push_back(8'h1C);
      @(negedge clk);
      chk("single_ready", {31'h0, bus.ready}, 1);
      chk("single_data", {24'h0, bus.data}, 32'h1C);
      pop();
      chk("single_empty_ready", {31'h0, bus.ready}, 0);
      chk("single_empty_data", {24'h0, bus.data}, 0);
      send(8'hF0); exp_q.push_back(8'hF0);
      send(8'h1C); exp_q.push_back(8'h1C);
      send(8'hF0); exp_q.push_back(8'hF0);
      chk("seq_ready", {31'h0, bus.ready}, 1);
      repeat (3) pop();
      chk("seq_drained", {31'h0, bus.ready}, 0);
      chk("seq_no_err", err_seen, err_exp);
      send(8'h1C, 1);
      err_exp++;
      chk("parity_err", err_seen, err_exp);
      chk("parity_ready", {31'h0, bus.ready}, 0);
      send(8'h32); exp_q.push_back(8'h32);
      chk("after_parity_data", {24'h0, bus.data}, 32'h32);
      pop();
      send(8'h45, 0, 1);
      err_exp++;
      chk("stop_err", err_seen, err_exp);
      chk("stop_ready", {31'h0, bus.ready}, 0);
      for (int i = 1; i <= 8; i++) begin
         send(8'(i));
         if (i < 8) exp_q.push_back(8'(i));
      end
      chk("ovf_flag", {31'h0, bus.overflow}, 1);
      chk("ovf_head", {24'h0, bus.data}, 32'h01);
      pop();
      chk("ovf_cleared", {31'h0, bus.overflow}, 0);
      repeat (6) pop();
      chk("ovf_drained", {31'h0, bus.ready}, 0);
      pop();
      chk("pop_empty_ready", {31'h0, bus.ready}, 0);
      chk("pop_empty_data", {24'h0, bus.data}, 0);
      send(8'hA5, 0, 0, 5);
      repeat (TO + 20) @(negedge clk);
      err_exp++;
      chk("timeout_err", err_seen, err_exp);
      chk("timeout_ready", {31'h0, bus.ready}, 0);
      send(8'h5A); exp_q.push_back(8'h5A);
      chk("after_timeout_data", {24'h0, bus.data}, 32'h5A);
      pop();
      send(8'h11);
      chk("prereset_ready", {31'h0, bus.ready}, 1);
      send(8'h77, 0, 0, 6);
      #7 clrn = 1'b0;
      #1;
      chk("midreset_ready", {31'h0, bus.ready}, 0);
      chk("midreset_data", {24'h0, bus.data}, 0);
      chk("midreset_overflow", {31'h0, bus.overflow}, 0);
      chk("midreset_frame_err", {31'h0, bus.frame_err}, 0);
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      send(8'h29); exp_q.push_back(8'h29);
      chk("after_reset_ready", {31'h0, bus.ready}, 1);
      chk("after_reset_data", {24'h0, bus.data}, 32'h29);
      pop();
      chk("final_ready", {31'h0, bus.ready}, 0);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("final_err_count", err_seen, err_exp);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
